// File: rtl/vec_mem_unit.sv
// Strided vector load/store sequencer on RAM port B: one element access per cycle,
// load data gathered across the one-cycle RAM read latency, returned via valid/ready.

module vec_mem_lane #(
  parameter int DATA_W = 32,
  parameter int VL_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap_en,
  input  logic [VL_W-1:0]   cap_idx,
  input  logic [VL_W-1:0]   lane_id,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           q <= '0;
    else if (clr)                         q <= '0;
    else if (cap_en && cap_idx == lane_id) q <= din;
  end
endmodule

module vec_mem_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MAX_VL = 8,
  parameter int VL_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [ADDR_W-1:0]        req_base,
  input  logic [ADDR_W-1:0]        req_stride,
  input  logic [VL_W-1:0]          req_vl,
  input  logic [MAX_VL*DATA_W-1:0] req_data,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_store,
  output logic [MAX_VL*DATA_W-1:0] resp_data,
  output logic                     busy
);
  localparam int IDX_W = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                     state;
  logic [ADDR_W-1:0]              addr_q, stride_q;
  logic [VL_W-1:0]                vl_q, idx, cap_idx;
  logic                           store_q, cap_vld;
  logic [MAX_VL-1:0][DATA_W-1:0]  data_q, lane_q;
  logic [VL_W-1:0]                vl_clamp;
  logic                           accept, issue, issue_ld;

  assign vl_clamp = (req_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : req_vl;
  assign accept   = req_valid && (state == S_IDLE);
  assign issue    = (state == S_ISSUE);
  assign issue_ld = issue && !store_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      idx      <= '0;
      store_q  <= 1'b0;
      data_q   <= '0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
    end else begin
      // Read issued this cycle returns next cycle; remember which lane it belongs to.
      cap_vld <= issue_ld;
      cap_idx <= idx;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q   <= req_base;
          stride_q <= req_stride;
          vl_q     <= vl_clamp;
          store_q  <= req_store;
          data_q   <= req_data;
          idx      <= '0;
          state    <= (vl_clamp == '0) ? S_RESP : S_ISSUE;
        end
        S_ISSUE: begin
          addr_q <= addr_q + stride_q;
          idx    <= idx + VL_W'(1);
          if (idx == vl_q - VL_W'(1)) state <= store_q ? S_RESP : S_DRAIN;
        end
        S_DRAIN: state <= S_RESP;
        default: if (resp_ready) state <= S_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < MAX_VL; g++) begin : g_lane
      vec_mem_lane #(.DATA_W(DATA_W), .VL_W(VL_W)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .cap_en  (cap_vld),
        .cap_idx (cap_idx),
        .lane_id (VL_W'(g)),
        .din     (ram_dout),
        .q       (lane_q[g])
      );
    end
  endgenerate

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_store = store_q;
  assign resp_data  = lane_q;
  assign ram_we     = issue && store_q;
  assign ram_addr   = issue ? addr_q : '0;
  assign ram_din    = (issue && store_q) ? data_q[idx[IDX_W-1:0]] : '0;
endmodule

// File: tb/tb_vec_mem_unit.sv
// Randomized bench for vec_mem_unit: port-B RAM model plus a request-level
// reference memory predicting access sequence, response timing and load data.

module tb_vec_mem_unit;
  localparam int AW = 16, DW = 32, MV = 8, VW = 4;

  logic              clk, rst_n;
  logic              req_valid, req_ready, req_store;
  logic [AW-1:0]     req_base, req_stride;
  logic [VW-1:0]     req_vl;
  logic [MV*DW-1:0]  req_data;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din, ram_dout;
  logic              resp_valid, resp_ready, resp_store, busy;
  logic [MV*DW-1:0]  resp_data;

  vec_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .MAX_VL(MV), .VL_W(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl), .req_data(req_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_store(resp_store),
    .resp_data(resp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  // Port-B RAM: registered read, read-before-write.
  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = mem.exists(ram_addr) ? mem[ram_addr] : '0;
    if (ram_we) mem[ram_addr] = ram_din;
    ram_dout <= rd;
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [MV*DW-1:0] got, input logic [MV*DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MV*DW-1:0] rnd_vec();
    logic [MV*DW-1:0] v;
    for (int k = 0; k < MV; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic chk_reset_outs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_store", resp_store, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_busy", busy, 0);
  endtask

  // One full request: checks every cycle from accept to handshake.
  task automatic do_req(input logic st, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                        input logic [VW-1:0] vl, input logic [MV*DW-1:0] data, input int bp);
    int n, lat;
    logic [MV*DW-1:0] exp;
    logic [AW-1:0] a;
    n   = (vl > VW'(MV)) ? MV : int'(vl);
    lat = (n == 0) ? 1 : (st ? n + 1 : n + 2);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_store = st; req_base = base; req_stride = stride;
    req_vl = vl; req_data = data; resp_ready = 0;
    @(posedge clk);
    #1 req_valid = 0; req_data = rnd_vec(); req_base = $urandom; req_stride = $urandom;
    exp = '0;
    a   = base;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c <= n) begin
        chk("ram_we", ram_we, st);
        chk("ram_addr", ram_addr, a);
        if (st) begin
          chk("ram_din", ram_din, data[(c-1)*DW +: DW]);
          ref_mem[a] = data[(c-1)*DW +: DW];
        end else exp[(c-1)*DW +: DW] = ref_rd(a);
        a = a + stride;
      end else begin
        chk("ram_we_idle", ram_we, 0);
        chk("ram_addr_idle", ram_addr, 0);
      end
      chk("resp_valid_timing", resp_valid, c == lat);
    end
    chk("resp_data", resp_data, exp);
    chk("resp_store", resp_store, st);
    chk("busy", busy, 1);
    for (int b = 0; b < bp; b++) begin
      req_valid = 1; req_store = $urandom; req_vl = 4'd2;
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, exp);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 0; resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [MV*DW-1:0] d;
    rst_n = 0; req_valid = 0; req_store = 0; req_base = 0; req_stride = 0;
    req_vl = 0; req_data = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    rst_n = 1;
    @(negedge clk);
    chk_reset_outs();

    // Contiguous store then load.
    d = '0; d[0 +: DW] = 32'h11; d[DW +: DW] = 32'h22; d[2*DW +: DW] = 32'h33; d[3*DW +: DW] = 32'h44;
    do_req(1, 16'h0010, 16'h0001, 4'd4, d, 0);
    do_req(0, 16'h0010, 16'h0001, 4'd4, '0, 0);

    // Negative stride with address wrap.
    d = '0; d[0 +: DW] = 32'hAA; d[DW +: DW] = 32'hBB; d[2*DW +: DW] = 32'hCC;
    do_req(1, 16'h0001, 16'hFFFF, 4'd3, d, 0);
    do_req(0, 16'h0001, 16'hFFFF, 4'd3, '0, 0);

    // Zero-length and over-length requests.
    do_req(1, 16'h0010, 16'h0001, 4'd0, rnd_vec(), 0);
    do_req(0, 16'h0010, 16'h0001, 4'd0, '0, 0);
    do_req(1, 16'h0100, 16'h0003, 4'd12, rnd_vec(), 0);
    do_req(0, 16'h0100, 16'h0003, 4'd12, '0, 0);

    // Load response held under backpressure.
    do_req(0, 16'h0100, 16'h0003, 4'd8, '0, 5);

    for (int r = 0; r < 40; r++) begin
      logic [AW-1:0] st_r;
      case ($urandom_range(0, 4))
        0: st_r = 16'h0001;
        1: st_r = 16'hFFFF;
        2: st_r = 16'h0000;
        3: st_r = AW'($urandom_range(2, 5));
        default: st_r = AW'($urandom);
      endcase
      do_req(1'($urandom), AW'($urandom_range(0, 63)), st_r, VW'($urandom_range(0, 15)),
             rnd_vec(), $urandom_range(0, 3));
    end

    // Abort an 8-element store after three writes.
    do_req(1, 16'h0200, 16'h0001, 4'd8, rnd_vec(), 0);
    d = rnd_vec();
    @(negedge clk);
    req_valid = 1; req_store = 1; req_base = 16'h0200; req_stride = 16'h0001;
    req_vl = 4'd8; req_data = d;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1 chk_reset_outs();
    for (int k = 0; k < 3; k++) ref_mem[16'h0200 + AW'(k)] = d[k*DW +: DW];
    repeat (2) @(posedge clk);
    for (int k = 0; k < MV; k++) chk("abort_ram_word", mem_rd(16'h0200 + AW'(k)), ref_rd(16'h0200 + AW'(k)));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    do_req(0, 16'h0200, 16'h0001, 4'd8, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
